// File: rtl/abxy_sweep_sequencer.sv
// Drives all 16 {A,B,x,y} vectors into a combinational stage, holding each for
// HOLD_CYCLES clocks, and captures f into a truth table plus a ones count.
module abxy_sweep_sequencer #(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic        A,
  output logic        B,
  output logic        x,
  output logic        y,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nx;
  logic [3:0]       idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [15:0]      tt_nx;
  logic [4:0]       ones_nx;

  always_comb begin
    // NOTE: every next-value starts as "hold current" so no path leaves it unassigned (no latch).
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    tt_nx    = truth_table;
    ones_nx  = ones_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = APPLY;
          idx_nx   = '0;
          cnt_nx   = '0;
          tt_nx    = '0;
          ones_nx  = '0;
        end
      end
      APPLY: begin
        if (cnt == LAST_HOLD) begin
          tt_nx[idx] = f;
          ones_nx    = ones_count + {4'b0, f};
          cnt_nx     = '0;
          // Terminal check precedes the increment, so idx never wraps.
          if (idx == 4'hF) state_nx = DONE;
          else             idx_nx   = idx + 4'd1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      truth_table <= '0;
      ones_count  <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      truth_table <= tt_nx;
      ones_count  <= ones_nx;
    end
  end

  // Outputs decode registered state only; start and f never reach them combinationally.
  assign busy         = (state == APPLY);
  assign done         = (state == DONE);
  assign {A, B, x, y} = busy ? idx : 4'h0;

endmodule

// File: tb/tb_abxy_sweep_sequencer.sv
// Bench for abxy_sweep_sequencer: directed and random f functions, noise inside
// hold windows, ignored start pulses, mid-sweep reset, and a HOLD_CYCLES=1 instance.
module tb_abxy_sweep_sequencer;

  localparam int HOLD = 20;

  logic clk, rst;
  logic start, f;
  logic va, vb, vx, vy, busy, done;
  logic [15:0] tt;
  logic [4:0]  ones;

  logic start1, f1;
  logic a1, b1, x1, y1, busy1, done1;
  logic [15:0] tt1;
  logic [4:0]  ones1;

  int n_cmp = 0;
  int n_bad = 0;

  abxy_sweep_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .f(f),
    .A(va), .B(vb), .x(vx), .y(vy), .busy(busy), .done(done),
    .truth_table(tt), .ones_count(ones)
  );

  abxy_sweep_sequencer #(.HOLD_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f(f1),
    .A(a1), .B(b1), .x(x1), .y(y1), .busy(busy1), .done(done1),
    .truth_table(tt1), .ones_count(ones1)
  );

  // Combinational stage modelled as A&B for the single-cycle-hold instance.
  assign f1 = a1 & b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vec"},  {28'd0, va, vb, vx, vy}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_tt"},   {16'd0, tt},   32'd0);
    chk({tag, "_ones"}, {27'd0, ones}, 32'd0);
  endtask

  // One sweep on the HOLD=20 instance. fn[i] is the value f must present for vector i.
  // With noise, f is random except on the cycle leading into each sampling edge.
  task automatic sweep(input logic [15:0] fn, input bit noise, input bit poke,
                       input int abort_vec);
    int total;
    int vec;
    total = 16 * HOLD;
    start = 1'b1;
    step();                               // start edge k has passed
    start = 1'b0;
    for (int j = 0; j < total; j++) begin
      vec = j / HOLD;
      if (abort_vec >= 0 && j == abort_vec * HOLD + 5) begin
        #3 rst = 1'b1;
        #1 chk_zero("abort");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
          step();
          chk("abort_no_done", {31'd0, done}, 32'd0);
          chk("abort_idle",    {31'd0, busy}, 32'd0);
        end
        chk("abort_tt_clear", {16'd0, tt}, 32'd0);
        return;
      end
      if (j % HOLD == 0) begin
        chk("vec",       {28'd0, va, vb, vx, vy}, vec);
        chk("busy_high", {31'd0, busy}, 32'd1);
        chk("done_low",  {31'd0, done}, 32'd0);
      end
      if (!noise || (j + 1) % HOLD == 0) f = fn[vec];
      else                               f = 1'($urandom_range(0, 1));
      start = poke && (j == 5 * HOLD + 3);
      step();
    end
    // Now just after edge k + 16*HOLD: DONE cycle.
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy",  {31'd0, busy}, 32'd0);
    chk("done_vec",   {28'd0, va, vb, vx, vy}, 32'd0);
    chk("tt",         {16'd0, tt}, {16'd0, fn});
    chk("ones",       {27'd0, ones}, $countones(fn));
    start = poke;
    step();
    start = 1'b0;
    chk("done_end",   {31'd0, done}, 32'd0);
    chk("idle_busy",  {31'd0, busy}, 32'd0);
    step();
    chk("no_restart", {31'd0, busy}, 32'd0);
    chk("tt_retain",  {16'd0, tt}, {16'd0, fn});
  endtask

  initial begin
    logic [15:0] rfn;
    rst = 1'b0; start = 1'b0; f = 1'b0; start1 = 1'b0;

    // Reset asserted before any clock edge must zero outputs immediately.
    #3 rst = 1'b1;
    #1 chk_zero("reset");
    chk("reset_busy1", {31'd0, busy1}, 32'd0);
    chk("reset_tt1",   {16'd0, tt1},   32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    sweep(16'hF000, 1'b0, 1'b0, -1);     // f = A & B
    sweep(16'h6666, 1'b1, 1'b0, -1);     // f = x ^ y
    sweep(16'hFFFF, 1'b1, 1'b0, -1);     // ones_count reaches 16
    sweep(16'h0000, 1'b1, 1'b0, -1);
    sweep(16'hA5C3, 1'b1, 1'b1, -1);     // start pokes in APPLY and DONE
    sweep(16'h5A5A, 1'b1, 1'b0, 9);      // reset at vector 9
    for (int r = 0; r < 3; r++) begin
      rfn = 16'($urandom);
      sweep(rfn, 1'b1, 1'b0, -1);
    end

    // HOLD_CYCLES = 1: one vector per cycle, done after 16 APPLY cycles.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("h1_vec",  {28'd0, a1, b1, x1, y1}, j);
      chk("h1_busy", {31'd0, busy1}, 32'd1);
      step();
    end
    chk("h1_done", {31'd0, done1}, 32'd1);
    chk("h1_tt",   {16'd0, tt1},   32'h0000F000);
    chk("h1_ones", {27'd0, ones1}, 32'd4);
    step();
    chk("h1_done_end", {31'd0, done1}, 32'd0);
    chk("h1_idle",     {31'd0, busy1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
